// File: rtl/gates_bist_pkg.sv
// gates_bist_pkg
//   Shared definitions for the gates BIST controller: FSM state encoding,
//   settle-time default and legal limits, and the expected-response table
//   for the AND/OR/XOR gates unit (indexed by stimulus {a,b}).
package gates_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned SETTLE_DEF = 2;
   localparam int unsigned SETTLE_MIN = 1;
   localparam int unsigned SETTLE_MAX = 15;

   localparam int unsigned NUM_VEC = 4;
   localparam logic [2:0]  ERR_MAX = 3'd4;

   // resp[0:2] = {a AND b, a OR b, a XOR b}, a = stim[0], b = stim[1]
   localparam logic [0:2] EXP_RESP [NUM_VEC] = '{3'b000, 3'b011, 3'b011, 3'b110};

endpackage

// File: rtl/gates_bist_if.sv
// gates_bist_if
//   Bus between the BIST controller and its environment.
//   start     : run request (environment -> BIST)
//   stim[0:1] : stimulus vector to the gates unit (BIST -> env)
//   resp[0:2] : gates unit response (env -> BIST)
//   busy/done/pass/err_count/fail_vec : run status (BIST -> env)
interface gates_bist_if;

   logic        start;
   logic [0:1]  stim;
   logic [0:2]  resp;
   logic        busy;
   logic        done;
   logic        pass;
   logic [2:0]  err_count;
   logic [0:3]  fail_vec;

   modport master (
      output start, resp,
      input  stim, busy, done, pass, err_count, fail_vec
   );

   modport slave (
      input  start, resp,
      output stim, busy, done, pass, err_count, fail_vec
   );

endinterface

// File: rtl/gates_bist_ref_model.sv
// gates_ref_model
//   Combinational expected-response lookup for the gates unit.
//   i_stim[0:1] : stimulus vector {a,b}
//   o_exp[0:2]  : expected response {AND, OR, XOR}
module gates_ref_model
   import gates_bist_pkg::*;
(
   input  logic [0:1] i_stim,
   output logic [0:2] o_exp
);

   assign o_exp = EXP_RESP[i_stim];

endmodule

// File: rtl/gates_bist.sv
// gates_bist
//   Built-in self test for a 2-input AND/OR/XOR gates unit. On start it
//   walks the four input vectors, holds each for SETTLE cycles, checks the
//   response for one cycle, and reports per-vector failures, a saturating
//   mismatch count and an overall pass flag.
//   Clk     : rising-edge clock
//   Reset_L : asynchronous active-low reset
//   bus     : start/stim/resp handshake and status outputs (slave side)
module gates_bist
   import gates_bist_pkg::*;
#(
   parameter int unsigned SETTLE = SETTLE_DEF
)(
   input  logic          Clk,
   input  logic          Reset_L,
   gates_bist_if.slave   bus
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_idx;
   logic [3:0]  r_settle;
   logic [2:0]  r_err;
   logic [0:3]  r_fail;
   logic        r_pass;

   logic [0:1]  w_stim;
   logic [0:2]  w_exp;
   logic        w_settle_last;
   logic        w_mismatch;

   // Stimulus is only presented while a vector is live; idle/done park at 00.
   assign w_stim        = (r_state == ST_APPLY || r_state == ST_CHECK) ? r_idx : 2'b00;
   assign w_settle_last = (r_settle == SETTLE_LAST);
   assign w_mismatch    = (bus.resp != w_exp);

   gates_ref_model u_ref (
      .i_stim (w_stim),
      .o_exp  (w_exp)
   );

   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start)     w_state_nxt = ST_APPLY;
         ST_APPLY: if (w_settle_last) w_state_nxt = ST_CHECK;
         ST_CHECK: w_state_nxt = (r_idx == 2'd3) ? ST_DONE : ST_APPLY;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         r_idx    <= '0;
         r_settle <= '0;
         r_err    <= '0;
         r_fail   <= '0;
         r_pass   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_idx    <= '0;
                  r_settle <= '0;
                  r_err    <= '0;
                  r_fail   <= '0;
                  r_pass   <= 1'b0;
               end
            end
            ST_APPLY: r_settle <= w_settle_last ? 4'd0 : r_settle + 4'd1;
            ST_CHECK: begin
               if (w_mismatch) begin
                  r_err         <= (r_err >= ERR_MAX) ? ERR_MAX : r_err + 3'd1;
                  r_fail[r_idx] <= 1'b1;
               end
               // wraps 3 -> 0 on the way to DONE, ready for the next run
               r_idx <= r_idx + 2'd1;
            end
            ST_DONE: r_pass <= (r_err == 3'd0);
            default: ;
         endcase
      end
   end

   assign bus.stim      = w_stim;
   assign bus.busy      = (r_state == ST_APPLY) || (r_state == ST_CHECK);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.pass      = r_pass;
   assign bus.err_count = r_err;
   assign bus.fail_vec  = r_fail;

endmodule

// File: tb/tb_gates_bist.sv
// tb_gates_bist
//   Randomized self-checking bench. Two BIST instances (SETTLE=2 and 1)
//   drive a behavioural gates unit whose per-vector response can be
//   corrupted by an XOR mask; the expected run outcome is derived from
//   the masks, and timing from the vector/settle arithmetic.
module tb_gates_bist;

   logic Clk = 1'b0;
   logic Reset_L = 1'b0;
   always #5 Clk = ~Clk;

   gates_bist_if bus_a();
   gates_bist_if bus_b();

   gates_bist #(.SETTLE(2)) u_dut_a (.Clk(Clk), .Reset_L(Reset_L), .bus(bus_a.slave));
   gates_bist #(.SETTLE(1)) u_dut_b (.Clk(Clk), .Reset_L(Reset_L), .bus(bus_b.slave));

   logic [0:2] mask_a [4];
   logic [0:2] mask_b [4];
   int total = 0;
   int bad   = 0;

   function automatic logic [0:2] golden(input logic [1:0] v);
      logic a, b;
      a = v[1];
      b = v[0];
      return {a & b, a | b, a ^ b};
   endfunction

   // behavioural gates units, optionally corrupted per vector
   always_comb bus_a.resp = golden(bus_a.stim) ^ mask_a[bus_a.stim];
   always_comb bus_b.resp = golden(bus_b.stim) ^ mask_b[bus_b.stim];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // 0: healthy, 1: resp[2] stuck at 0, 2: always 111, 3: random corruption
   task automatic set_mask(input int mode);
      for (int v = 0; v < 4; v++) begin
         logic [0:2] g;
         g = golden(2'(v));
         case (mode)
            1:       mask_a[v] = {2'b00, g[2]};
            2:       mask_a[v] = g ^ 3'b111;
            3:       mask_a[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
            default: mask_a[v] = 3'b000;
         endcase
      end
   endtask

   task automatic idle_check(input int n);
      int cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge Clk);
         if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) cnt++;
      end
      chk("idle_no_run", cnt, 0);
   endtask

   // One full run on DUT A; p1/p2 are cycles (relative to accept) at which
   // a stray start pulse is presented and must be ignored.
   task automatic run_a(input int S, input int p1, input int p2);
      logic [0:3] ef;
      int ee, first_done, n_done, n_busy_bad, n_stim_bad, run_len;
      ee = 0;
      for (int v = 0; v < 4; v++) begin
         ef[v] = (mask_a[v] != 3'b000);
         if (ef[v]) ee++;
      end
      first_done = -1; n_done = 0; n_busy_bad = 0; n_stim_bad = 0;
      run_len = 4 * (S + 1);
      @(negedge Clk);
      bus_a.start = 1'b1;
      for (int k = 1; k <= run_len + 5; k++) begin
         logic exp_busy;
         int   exp_stim;
         @(negedge Clk);
         exp_busy = (k <= run_len);
         exp_stim = exp_busy ? (k - 1) / (S + 1) : 0;
         if (bus_a.busy !== exp_busy) n_busy_bad++;
         if (int'(bus_a.stim) != exp_stim) n_stim_bad++;
         if (bus_a.done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
         if (k == 1) begin
            chk("clr_pass", bus_a.pass, 0);
            chk("clr_err", bus_a.err_count, 0);
            chk("clr_fail", bus_a.fail_vec, 0);
         end
         if (k == run_len + 2) begin
            chk("err_count", bus_a.err_count, ee);
            chk("fail_vec", bus_a.fail_vec, ef);
            chk("pass", bus_a.pass, (ee == 0));
         end
         bus_a.start = (k == p1 || k == p2);
      end
      chk("done_cycle", first_done, run_len + 1);
      chk("done_count", n_done, 1);
      chk("busy_window", n_busy_bad, 0);
      chk("stim_seq", n_stim_bad, 0);
      chk("hold_err", bus_a.err_count, ee);
      chk("hold_fail", bus_a.fail_vec, ef);
      chk("hold_pass", bus_a.pass, (ee == 0));
   endtask

   initial begin
      int d1, d2, nd;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      for (int v = 0; v < 4; v++) begin
         mask_a[v] = 3'b000;
         mask_b[v] = 3'b000;
      end

      #3;
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_done", bus_a.done, 0);
      chk("rst_pass", bus_a.pass, 0);
      chk("rst_err", bus_a.err_count, 0);
      chk("rst_fail", bus_a.fail_vec, 0);
      chk("rst_stim", bus_a.stim, 0);
      chk("rst_b_busy", bus_b.busy, 0);
      repeat (3) @(negedge Clk);
      Reset_L = 1'b1;
      idle_check(8);

      set_mask(0); run_a(2, 0, 0);
      set_mask(1); run_a(2, 0, 0);
      set_mask(2); run_a(2, 0, 0);
      set_mask(0); run_a(2, 3, 12);

      for (int r = 0; r < 10; r++) begin
         set_mask(3);
         repeat ($urandom_range(0, 3)) @(negedge Clk);
         run_a(2, $urandom_range(2, 13), $urandom_range(2, 13));
      end

      // reset mid-run, during APPLY of vector 2 (cycles 7..8)
      set_mask(0); run_a(2, 0, 0);
      set_mask(1);
      @(negedge Clk);
      bus_a.start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge Clk);
         bus_a.start = 1'b0;
      end
      chk("pre_rst_err", bus_a.err_count, 1);
      chk("pre_rst_stim", bus_a.stim, 2);
      #2 Reset_L = 1'b0;
      #1;
      chk("arst_busy", bus_a.busy, 0);
      chk("arst_stim", bus_a.stim, 0);
      chk("arst_done", bus_a.done, 0);
      chk("arst_pass", bus_a.pass, 0);
      chk("arst_err", bus_a.err_count, 0);
      chk("arst_fail", bus_a.fail_vec, 0);
      repeat (2) @(negedge Clk);
      Reset_L = 1'b1;
      idle_check(20);
      set_mask(0); run_a(2, 0, 0);

      // back-to-back runs on DUT B (SETTLE=1) with start held high
      d1 = -1; d2 = -1; nd = 0;
      @(negedge Clk);
      bus_b.start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge Clk);
         if (bus_b.done === 1'b1) begin
            nd++;
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k == 10) begin
            chk("b2b_gap_busy", bus_b.busy, 0);
            chk("b2b_pass", bus_b.pass, 1);
         end
         if (k == 11) bus_b.start = 1'b0;
      end
      chk("b2b_done1", d1, 9);
      chk("b2b_done2", d2, 19);
      chk("b2b_count", nd, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
